// File: rtl/capture_x_if.sv
// Peripheral bus bundle for the capture unit: write strobe, register
// select, write data, read data and interrupt.
interface capture_x_if;
  logic        cap_we;
  logic [1:0]  cap_ch;
  logic [31:0] cap_val;
  logic [31:0] cap_out;
  logic        cap_irq;

  // CPU side drives the strobe/select/data and sees read data and interrupt.
  modport master (
    output cap_we,
    output cap_ch,
    output cap_val,
    input  cap_out,
    input  cap_irq
  );

  // Capture unit side.
  modport slave (
    input  cap_we,
    input  cap_ch,
    input  cap_val,
    output cap_out,
    output cap_irq
  );
endinterface

// File: rtl/capture_x.sv
// Three-input timer capture unit. Measures period, high width or low width
// of one selected (synchronized) input in clk ticks, or counts rising edges
// over a tick window. Bus registers: ch0 timeout/result, ch1 arm/status,
// ch2 clear/live counter, ch3 control.
module capture_x #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cap_in,
  capture_x_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    MEASURE    = 3'd2,
    DONE       = 3'd3
  } state_t;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  state_t      state;
  logic [31:0] timeout;
  logic [31:0] result;
  logic [31:0] cnt;
  logic [31:0] ecnt;
  logic [4:0]  ctrl;
  logic        done;
  logic        ovf;

  logic [2:0]  synced;
  logic [2:0]  prev;
  logic [2:0]  rise;
  logic [2:0]  fall;

  // Per-bit synchronizer chains; every bit has the same depth so that the
  // relative timing of edges (and hence measured widths) is preserved.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      // Shift the raw input through the synchronizer flops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], cap_in[gi]};
      end

      assign synced[gi] = chain[SYNC_STAGES-1];
    end
  endgenerate

  // Edge-detect register: previous synchronized value of each bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= synced;
  end

  assign rise = synced & ~prev;
  assign fall = ~synced & prev;

  // Control field decode; select value 3 falls back to input 0.
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic        irq_en;
  logic        rise_sel;
  logic        fall_sel;
  logic        start_ev;
  logic        stop_ev;
  logic        to_hit;
  logic [31:0] cnt_inc;

  assign sel      = (ctrl[1:0] == 2'd3) ? 2'd0 : ctrl[1:0];
  assign mode     = ctrl[3:2];
  assign irq_en   = ctrl[4];
  assign rise_sel = rise[sel];
  assign fall_sel = fall[sel];

  // Low-width mode starts on a falling edge; all others start on a rise.
  assign start_ev = (mode == 2'b10) ? fall_sel : rise_sel;
  // High-width mode stops on a falling edge; period and low width on a rise.
  assign stop_ev  = (mode == 2'b01) ? fall_sel : rise_sel;

  // A zero timeout disables the limit entirely.
  assign to_hit   = (timeout != 32'd0) && (cnt == timeout);

  // Tick counter saturates rather than wrapping.
  assign cnt_inc  = (cnt == ALL_ONES) ? cnt : cnt + 32'd1;

  // Bus writes and measurement FSM. Arm, clear and control writes take
  // priority over anything the FSM would do in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timeout <= '0;
      result  <= '0;
      cnt     <= '0;
      ecnt    <= '0;
      ctrl    <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (bus.cap_we && bus.cap_ch == 2'd0) begin
        timeout <= bus.cap_val;
      end

      if (bus.cap_we && bus.cap_ch != 2'd0) begin
        case (bus.cap_ch)
          2'd1: begin
            done  <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            ecnt  <= '0;
            state <= WAIT_START;
          end
          2'd2: begin
            done  <= 1'b0;
            ovf   <= 1'b0;
            state <= IDLE;
          end
          default: begin
            ctrl  <= bus.cap_val[4:0];
            done  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end else begin
        case (state)
          WAIT_START: begin
            cnt <= cnt_inc;
            if (start_ev) begin
              cnt   <= 32'd1;
              ecnt  <= '0;
              state <= MEASURE;
            end else if (mode != 2'b11 && to_hit) begin
              ovf    <= 1'b1;
              done   <= 1'b1;
              result <= ALL_ONES;
              state  <= DONE;
            end
          end
          MEASURE: begin
            if (mode == 2'b11) begin
              cnt <= cnt_inc;
              if (rise_sel) ecnt <= ecnt + 32'd1;
              if (to_hit) begin
                result <= ecnt + {31'd0, rise_sel};
                done   <= 1'b1;
                state  <= DONE;
              end
            end else if (stop_ev) begin
              result <= cnt;
              done   <= 1'b1;
              state  <= DONE;
            end else if (to_hit) begin
              ovf    <= 1'b1;
              done   <= 1'b1;
              result <= ALL_ONES;
              state  <= DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            // IDLE and DONE hold everything.
          end
        endcase
      end
    end
  end

  // Register read mux; reads have no side effects.
  always_comb begin
    bus.cap_out = result;
    case (bus.cap_ch)
      2'd0:    bus.cap_out = result;
      2'd1:    bus.cap_out = {27'd0, ovf, done, state};
      2'd2:    bus.cap_out = cnt;
      default: bus.cap_out = {27'd0, ctrl};
    endcase
  end

  assign bus.cap_irq = done & irq_en;

endmodule

// File: tb/tb_capture_x.sv
// Directed bench for capture_x: period, widths, timeout, edge count,
// bus/event conflicts and mid-measurement reset.
module tb_capture_x;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cap_in;

  capture_x_if bus ();

  capture_x #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk    (clk),
    .rst    (rst),
    .cap_in (cap_in),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] ch, input logic [31:0] exp);
    bus.cap_ch = ch;
    #1;
    check(tag, bus.cap_out, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following rising edge.
  task automatic bus_write(input logic [1:0] ch, input logic [31:0] val);
    bus.cap_we  = 1'b1;
    bus.cap_ch  = ch;
    bus.cap_val = val;
    @(negedge clk);
    bus.cap_we  = 1'b0;
    bus.cap_val = '0;
  endtask

  initial begin
    rst         = 1'b1;
    cap_in      = 3'b000;
    bus.cap_we  = 1'b0;
    bus.cap_ch  = 2'd0;
    bus.cap_val = '0;
    tick(2);

    // Reset state
    check_reg("rst_result", 2'd0, 32'd0);
    check_reg("rst_status", 2'd1, 32'd0);
    check_reg("rst_cnt",    2'd2, 32'd0);
    check_reg("rst_ctrl",   2'd3, 32'd0);
    check("rst_irq", {31'd0, bus.cap_irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Period on input 0, irq enabled: rises 10 clk apart -> 10
    bus_write(2'd3, 32'h10);
    bus_write(2'd1, 32'd0);
    check_reg("arm_status", 2'd1, 32'h01);
    cap_in[0] = 1'b1; tick(5);
    cap_in[0] = 1'b0; tick(5);
    cap_in[0] = 1'b1; tick(5);
    cap_in[0] = 1'b0; tick(6);
    check_reg("period_result", 2'd0, 32'd10);
    check_reg("period_status", 2'd1, 32'h0B);
    check("period_irq", {31'd0, bus.cap_irq}, 32'd1);

    // High width on input 1: high 7 clk -> 7; irq disabled
    bus_write(2'd3, 32'h05);
    check("ctrl_write_irq", {31'd0, bus.cap_irq}, 32'd0);
    bus_write(2'd1, 32'd0);
    cap_in[1] = 1'b1; tick(7);
    cap_in[1] = 1'b0; tick(8);
    check_reg("high_result", 2'd0, 32'd7);
    check_reg("high_status", 2'd1, 32'h0B);
    check("high_irq_off", {31'd0, bus.cap_irq}, 32'd0);

    // Low width on input 1: rise ignored, low 13 clk -> 13
    bus_write(2'd3, 32'h09);
    bus_write(2'd1, 32'd0);
    cap_in[1] = 1'b1; tick(5);
    cap_in[1] = 1'b0; tick(13);
    cap_in[1] = 1'b1; tick(8);
    check_reg("low_result", 2'd0, 32'd13);

    // Timeout 20 with static inputs: done exactly one cycle after cnt==20
    bus_write(2'd0, 32'd20);
    bus_write(2'd3, 32'h10);
    bus_write(2'd1, 32'd0);
    tick(20);
    check_reg("to_before_status", 2'd1, 32'h01);
    check_reg("to_before_cnt",    2'd2, 32'd20);
    tick(1);
    check_reg("to_status", 2'd1, 32'h1B);
    check_reg("to_result", 2'd0, 32'hFFFF_FFFF);
    check("to_irq", {31'd0, bus.cap_irq}, 32'd1);
    bus_write(2'd2, 32'd0);
    check("clear_irq", {31'd0, bus.cap_irq}, 32'd0);
    check_reg("clear_status", 2'd1, 32'h00);

    // Edge count on input 2, window 95, period 10: rises at +10..+90 -> 9
    bus_write(2'd0, 32'd95);
    bus_write(2'd3, 32'h0E);
    bus_write(2'd1, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cap_in[2] = 1'b1; tick(5);
      cap_in[2] = 1'b0; tick(5);
    end
    tick(4);
    check_reg("ecnt95_result", 2'd0, 32'd9);
    check_reg("ecnt95_status", 2'd1, 32'h0B);

    // Window 100: the rise at +100 lands with cnt==timeout and is counted -> 10
    bus_write(2'd0, 32'd100);
    bus_write(2'd1, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cap_in[2] = 1'b1; tick(5);
      cap_in[2] = 1'b0; tick(5);
    end
    tick(4);
    check_reg("ecnt100_result", 2'd0, 32'd10);
    check_reg("ecnt100_status", 2'd1, 32'h0B);

    // Stop edge coincident with an arm write: arm wins, result untouched
    bus_write(2'd0, 32'd0);
    bus_write(2'd3, 32'h00);
    bus_write(2'd1, 32'd0);
    cap_in[0] = 1'b1; tick(5);
    cap_in[0] = 1'b0; tick(7);
    cap_in[0] = 1'b1; tick(SYNC_STAGES);
    bus_write(2'd1, 32'd0);
    check_reg("conflict_arm_status", 2'd1, 32'h01);
    check_reg("conflict_arm_result", 2'd0, 32'd10);
    tick(3);
    check_reg("conflict_arm_later", 2'd1, 32'h01);

    // Stop edge in the same cycle as cnt==timeout: stop wins -> 12, ovf=0
    cap_in[0] = 1'b0; tick(4);
    bus_write(2'd0, 32'd12);
    bus_write(2'd1, 32'd0);
    cap_in[0] = 1'b1; tick(6);
    cap_in[0] = 1'b0; tick(6);
    cap_in[0] = 1'b1; tick(6);
    check_reg("stop_vs_to_result", 2'd0, 32'd12);
    check_reg("stop_vs_to_status", 2'd1, 32'h0B);

    // Stop edge one cycle past the timeout: overflow
    cap_in[0] = 1'b0; tick(4);
    bus_write(2'd1, 32'd0);
    cap_in[0] = 1'b1; tick(6);
    cap_in[0] = 1'b0; tick(7);
    cap_in[0] = 1'b1; tick(6);
    check_reg("late_stop_result", 2'd0, 32'hFFFF_FFFF);
    check_reg("late_stop_status", 2'd1, 32'h1B);

    // Reset in the middle of a measurement
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'd0);
    bus_write(2'd3, 32'h10);
    cap_in[0] = 1'b0; tick(4);
    bus_write(2'd1, 32'd0);
    cap_in[0] = 1'b1; tick(5);
    check_reg("pre_rst_status", 2'd1, 32'h02);
    rst = 1'b1;
    #1;
    check_reg("mid_rst_cnt",    2'd2, 32'd0);
    check_reg("mid_rst_result", 2'd0, 32'd0);
    check_reg("mid_rst_status", 2'd1, 32'd0);
    check_reg("mid_rst_ctrl",   2'd3, 32'd0);
    check("mid_rst_irq", {31'd0, bus.cap_irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cap_in[0] = 1'b0; tick(4);

    // Fresh period measurement after reset (ctrl back to 0)
    bus_write(2'd1, 32'd0);
    cap_in[0] = 1'b1; tick(5);
    cap_in[0] = 1'b0; tick(5);
    cap_in[0] = 1'b1; tick(5);
    cap_in[0] = 1'b0; tick(6);
    check_reg("post_rst_result", 2'd0, 32'd10);
    check_reg("post_rst_status", 2'd1, 32'h0B);
    check("post_rst_irq", {31'd0, bus.cap_irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
